// File: rtl/ifu_fetch_seq.sv
// Fetch sequencer: owns the fetch PC, issues one outstanding instruction-memory
// request at a time, arbitrates trap/mret/branch redirects and hands instructions to decode.
module ifu_fetch_seq #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        i_trap_req,
  input  logic [63:0] i_trap_pc,
  input  logic        i_mret_req,
  input  logic [63:0] i_mret_pc,
  input  logic        i_br_req,
  input  logic [63:0] i_br_pc,
  output logic        o_imem_req,
  output logic [63:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic        o_inst_valid,
  input  logic        i_inst_ready,
  output logic [31:0] o_inst,
  output logic [63:0] o_inst_pc,
  output logic [63:0] o_pc
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_WAIT  = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t      r_state;
  logic [63:0] r_pc;
  logic [63:0] r_inst_pc;
  logic [31:0] r_inst;
  logic        r_kill;
  logic        r_imem_req;
  logic        r_inst_valid;

  logic        w_redir;
  logic [63:0] w_tgt;
  logic [63:0] w_pc_inc;

  // Fixed-priority redirect select; losing requesters in the same cycle are dropped.
  always_comb begin
    w_redir = i_trap_req | i_mret_req | i_br_req;
    w_tgt   = i_br_pc;
    if (i_trap_req)
      w_tgt = i_trap_pc;
    else if (i_mret_req)
      w_tgt = i_mret_pc;
  end

  assign w_pc_inc = r_pc + 64'd4;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_PC;
      r_kill       <= 1'b0;
      r_inst       <= 32'd0;
      r_inst_pc    <= 64'd0;
      r_imem_req   <= 1'b0;
      r_inst_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_redir)
            r_pc <= w_tgt;
          r_state    <= S_FETCH;
          r_imem_req <= 1'b1;
        end

        S_FETCH: begin
          if (w_redir)
            r_pc <= w_tgt;
          if (i_imem_gnt) begin
            // The granted request targets the old pc, so its response must be discarded.
            if (w_redir)
              r_kill <= 1'b1;
            r_state    <= S_WAIT;
            r_imem_req <= 1'b0;
          end
        end

        S_WAIT: begin
          if (w_redir)
            r_pc <= w_tgt;
          if (i_imem_rvalid) begin
            if (r_kill || w_redir) begin
              r_kill     <= 1'b0;
              r_state    <= S_FETCH;
              r_imem_req <= 1'b1;
            end else begin
              r_inst       <= i_imem_rdata;
              r_inst_pc    <= r_pc;
              r_state      <= S_HOLD;
              r_inst_valid <= 1'b1;
            end
          end else if (w_redir) begin
            r_kill <= 1'b1;
          end
        end

        S_HOLD: begin
          // A redirect wins over pc+4 even if decode accepts in the same cycle.
          if (w_redir || i_inst_ready) begin
            r_pc         <= w_redir ? w_tgt : w_pc_inc;
            r_state      <= S_FETCH;
            r_imem_req   <= 1'b1;
            r_inst_valid <= 1'b0;
          end
        end

        default: begin
          r_state      <= S_IDLE;
          r_imem_req   <= 1'b0;
          r_inst_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_imem_req   = r_imem_req;
  assign o_imem_addr  = {r_pc[63:2], 2'b00};
  assign o_inst_valid = r_inst_valid;
  assign o_inst       = r_inst;
  assign o_inst_pc    = r_inst_pc;
  assign o_pc         = r_pc;

endmodule

// File: tb/tb_ifu_fetch_seq.sv
// Scenario bench for ifu_fetch_seq: a scripted memory drives the handshake and a
// scoreboard queue holds the instruction/pc each granted fetch must deliver to decode.
module tb_ifu_fetch_seq;

  typedef struct {
    logic [31:0] inst;
    logic [63:0] pc;
  } sb_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic        trap_req, mret_req, br_req;
  logic [63:0] trap_pc, mret_pc, br_pc;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_gnt, imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid, inst_ready;
  logic [31:0] inst;
  logic [63:0] inst_pc, pc;

  // Second instance exercising the pc+4 wrap at the top of the address space.
  logic        rstn2, gnt2, rvalid2, ready2;
  logic [31:0] rdata2;
  logic        zero1;
  logic [63:0] zero64;
  logic        req2, valid2;
  logic [63:0] addr2, instpc2, pc2;
  logic [31:0] inst2;

  int errors = 0;
  int checks = 0;
  sb_t sb_q[$];

  always #5 clk = ~clk;

  ifu_fetch_seq dut (
    .clk(clk), .rstn(rstn),
    .i_trap_req(trap_req), .i_trap_pc(trap_pc),
    .i_mret_req(mret_req), .i_mret_pc(mret_pc),
    .i_br_req(br_req), .i_br_pc(br_pc),
    .o_imem_req(imem_req), .o_imem_addr(imem_addr),
    .i_imem_gnt(imem_gnt), .i_imem_rvalid(imem_rvalid), .i_imem_rdata(imem_rdata),
    .o_inst_valid(inst_valid), .i_inst_ready(inst_ready),
    .o_inst(inst), .o_inst_pc(inst_pc), .o_pc(pc)
  );

  ifu_fetch_seq #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut_wrap (
    .clk(clk), .rstn(rstn2),
    .i_trap_req(zero1), .i_trap_pc(zero64),
    .i_mret_req(zero1), .i_mret_pc(zero64),
    .i_br_req(zero1), .i_br_pc(zero64),
    .o_imem_req(req2), .o_imem_addr(addr2),
    .i_imem_gnt(gnt2), .i_imem_rvalid(rvalid2), .i_imem_rdata(rdata2),
    .o_inst_valid(valid2), .i_inst_ready(ready2),
    .o_inst(inst2), .o_inst_pc(instpc2), .o_pc(pc2)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ 32'h5A5A_0013;
  endfunction

  task automatic wait_req(input string nm);
    int n = 0;
    while (!imem_req && n < 8) begin
      tick();
      n++;
    end
    checks++;
    if (imem_req !== 1'b1) begin
      errors++;
      $display("FAIL %s imem_req timeout got=%b exp=1", nm, imem_req);
    end
  endtask

  // Grant the pending request at exp_addr, return data next cycle, leave DUT in HOLD.
  task automatic fetch_one(input string nm, input logic [63:0] exp_addr, input logic [31:0] data);
    sb_t e, got;
    wait_req(nm);
    checks++;
    if (imem_addr !== exp_addr) begin
      errors++;
      $display("FAIL %s imem_addr got=%h exp=%h", nm, imem_addr, exp_addr);
    end
    e.inst = data;
    e.pc   = exp_addr;
    sb_q.push_back(e);
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    checks++;
    if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s wait req/valid got=%b%b exp=00", nm, imem_req, inst_valid);
    end
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    tick();
    imem_rvalid = 1'b0;
    imem_rdata  = 32'hBAD0_BAD0;
    checks++;
    if (inst_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s inst_valid got=%b exp=1", nm, inst_valid);
    end
    if (sb_q.size() > 0) begin
      got = sb_q.pop_front();
      checks++;
      if (inst !== got.inst || inst_pc !== got.pc) begin
        errors++;
        $display("FAIL %s inst/inst_pc got=%h/%h exp=%h/%h", nm, inst, inst_pc, got.inst, got.pc);
      end
    end
  endtask

  task automatic accept(input string nm, input logic [63:0] next_addr);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    checks++;
    if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== next_addr) begin
      errors++;
      $display("FAIL %s accept valid/req/addr got=%b/%b/%h exp=0/1/%h",
               nm, inst_valid, imem_req, imem_addr, next_addr);
    end
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    tick();
    tick();
    checks++;
    if (imem_req !== 1'b0 || inst_valid !== 1'b0 || inst !== 32'd0 || inst_pc !== 64'd0 ||
        pc !== 64'h8000_0000) begin
      errors++;
      $display("FAIL reset_state got req=%b v=%b inst=%h ipc=%h pc=%h exp 0/0/0/0/80000000",
               imem_req, inst_valid, inst, inst_pc, pc);
    end
    rstn = 1'b1;
    fetch_one("reset_fetch", 64'h8000_0000, 32'h0000_0013);
    accept("reset_accept", 64'h8000_0004);
  endtask

  task automatic test_backpressure;
    logic [31:0] d;
    d = mem_word(64'h8000_0004);
    fetch_one("bp_fetch", 64'h8000_0004, d);
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (inst_valid !== 1'b1 || imem_req !== 1'b0 || inst !== d || inst_pc !== 64'h8000_0004) begin
        errors++;
        $display("FAIL bp_hold cyc%0d v/req/inst/ipc got=%b/%b/%h/%h exp=1/0/%h/80000004",
                 i, inst_valid, imem_req, inst, inst_pc, d);
      end
    end
    accept("bp_accept", 64'h8000_0008);
  endtask

  task automatic test_kill_wait;
    wait_req("kill_req");
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    br_req = 1'b1;
    br_pc  = 64'h8000_1000;
    tick();
    br_req = 1'b0;
    checks++;
    if (pc !== 64'h8000_1000 || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL kill_br pc/req got=%h/%b exp=80001000/0", pc, imem_req);
    end
    mret_req = 1'b1;
    mret_pc  = 64'h8000_2000;
    tick();
    mret_req = 1'b0;
    checks++;
    if (pc !== 64'h8000_2000 || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL kill_second pc/req got=%h/%b exp=80002000/0", pc, imem_req);
    end
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    tick();
    imem_rvalid = 1'b0;
    checks++;
    if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 64'h8000_2000) begin
      errors++;
      $display("FAIL kill_drop v/req/addr got=%b/%b/%h exp=0/1/80002000", inst_valid, imem_req, imem_addr);
    end
  endtask

  task automatic test_fetch_redirect;
    br_req = 1'b1;
    br_pc  = 64'h8000_3002;
    tick();
    br_req = 1'b0;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h8000_3000 || pc !== 64'h8000_3002) begin
      errors++;
      $display("FAIL fetch_redir req/addr/pc got=%b/%h/%h exp=1/80003000/80003002", imem_req, imem_addr, pc);
    end
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    imem_rvalid = 1'b1;
    br_req      = 1'b1;
    br_pc       = 64'h8000_4000;
    tick();
    imem_rvalid = 1'b0;
    br_req      = 1'b0;
    checks++;
    if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 64'h8000_4000) begin
      errors++;
      $display("FAIL wait_rvalid_redir v/req/addr got=%b/%b/%h exp=0/1/80004000", inst_valid, imem_req, imem_addr);
    end
  endtask

  task automatic test_priority;
    fetch_one("prio_fetch", 64'h8000_4000, mem_word(64'h8000_4000));
    trap_req = 1'b1; trap_pc = 64'h8000_0100;
    mret_req = 1'b1; mret_pc = 64'h8000_0200;
    br_req   = 1'b1; br_pc   = 64'h8000_0300;
    inst_ready = 1'b1;
    tick();
    trap_req = 1'b0; mret_req = 1'b0; br_req = 1'b0; inst_ready = 1'b0;
    checks++;
    if (pc !== 64'h8000_0100 || inst_valid !== 1'b0 || imem_req !== 1'b1) begin
      errors++;
      $display("FAIL prio_trap pc/v/req got=%h/%b/%b exp=80000100/0/1", pc, inst_valid, imem_req);
    end
    fetch_one("prio_fetch2", 64'h8000_0100, mem_word(64'h8000_0100));
    mret_req = 1'b1;
    br_req   = 1'b1;
    tick();
    mret_req = 1'b0; br_req = 1'b0;
    checks++;
    if (pc !== 64'h8000_0200 || inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL prio_mret pc/v got=%h/%b exp=80000200/0", pc, inst_valid);
    end
  endtask

  task automatic test_back_to_back;
    logic [63:0] a;
    a = 64'h8000_0200;
    for (int i = 0; i < 4; i++) begin
      fetch_one("b2b_fetch", a, mem_word(a));
      accept("b2b_accept", a + 64'd4);
      a = a + 64'd4;
    end
  endtask

  task automatic test_reset_mid_wait;
    wait_req("rst_req");
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    rstn = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hCAFE_F00D;
    tick();
    tick();
    rstn = 1'b1;
    tick();
    imem_rvalid = 1'b0;
    tick();
    checks++;
    if (inst_valid !== 1'b0 || pc !== 64'h8000_0000) begin
      errors++;
      $display("FAIL rst_wait v/pc got=%b/%h exp=0/80000000", inst_valid, pc);
    end
    fetch_one("rst_refetch", 64'h8000_0000, 32'h0000_0093);
    accept("rst_accept", 64'h8000_0004);
  endtask

  task automatic test_wrap;
    int n = 0;
    rstn2 = 1'b1;
    while (!req2 && n < 8) begin
      tick();
      n++;
    end
    checks++;
    if (req2 !== 1'b1 || addr2 !== 64'hFFFF_FFFF_FFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_first req/addr got=%b/%h exp=1/fffffffffffffffc", req2, addr2);
    end
    gnt2 = 1'b1;
    tick();
    gnt2 = 1'b0;
    rvalid2 = 1'b1;
    rdata2  = 32'h1234_5678;
    tick();
    rvalid2 = 1'b0;
    checks++;
    if (valid2 !== 1'b1 || inst2 !== 32'h1234_5678 || instpc2 !== 64'hFFFF_FFFF_FFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_inst v/inst/ipc got=%b/%h/%h exp=1/12345678/fffffffffffffffc", valid2, inst2, instpc2);
    end
    ready2 = 1'b1;
    tick();
    ready2 = 1'b0;
    checks++;
    if (req2 !== 1'b1 || addr2 !== 64'd0 || pc2 !== 64'd0) begin
      errors++;
      $display("FAIL wrap_next req/addr/pc got=%b/%h/%h exp=1/0/0", req2, addr2, pc2);
    end
  endtask

  initial begin
    rstn = 1'b0;
    trap_req = 1'b0; mret_req = 1'b0; br_req = 1'b0;
    trap_pc = 64'd0; mret_pc = 64'd0; br_pc = 64'd0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;
    inst_ready = 1'b0;
    rstn2 = 1'b0; gnt2 = 1'b0; rvalid2 = 1'b0; ready2 = 1'b0; rdata2 = 32'd0;
    zero1 = 1'b0; zero64 = 64'd0;
    test_reset();
    test_backpressure();
    test_kill_wait();
    test_fetch_redirect();
    test_priority();
    test_back_to_back();
    test_reset_mid_wait();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
